video_fill_arbiter: RTL and testbench

- Owns the single write port of the 60x40 3-bit video memory.
- Arbitrates between two requesters: the CPU `VGA` instruction, which writes single pixels, and an internal rectangle-fill engine.
- The fill engine walks a programmed rectangle row-major and writes one pixel per cycle, used for clear-screen and box drawing.
- Sits between the MiniAlu datapath and the video RAM write port. Read/scan-out side is untouched.

---
 rtl/video_fill_arbiter.sv | 92 +++++++++
 tb/tb_video_fill_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fill_arbiter.sv
// video_fill_arbiter: owns the video RAM write port, giving CPU pixel writes priority over a row-major rectangle-fill engine.
// Ports: clk/rst_n (async active-low); cpu_req/cpu_col/cpu_row/cpu_color single-pixel CPU write;
// fill_start/x0/x1/y0/y1/fill_color rectangle fill request; vblank gates the fill when VIDEO_FILL_VBLANK_GATE_EN is defined;
// write_enable/write_address({col,row})/data_in registered RAM write; fill_busy/fill_done/fill_err status.
module video_fill_arbiter #(
  parameter int COLS    = 60,
  parameter int ROWS    = 40,
  parameter int COL_W   = 6,
  parameter int ROW_W   = 6,
  parameter int COLOR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic [COL_W-1:0]       cpu_col,
  input  logic [ROW_W-1:0]       cpu_row,
  input  logic [COLOR_W-1:0]     cpu_color,
  input  logic                   fill_start,
  input  logic [COL_W-1:0]       x0,
  input  logic [COL_W-1:0]       x1,
  input  logic [ROW_W-1:0]       y0,
  input  logic [ROW_W-1:0]       y1,
  input  logic [COLOR_W-1:0]     fill_color,
  input  logic                   vblank,
  output logic                   write_enable,
  output logic [COL_W+ROW_W-1:0] write_address,
  output logic [COLOR_W-1:0]     data_in,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   fill_err
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state;
  logic [COL_W-1:0] cx, lx0, lx1;
  logic [ROW_W-1:0] cy, ly1;
  logic [COLOR_W-1:0] color;
  logic adv, valid;
  assign valid = x0 <= x1 && y0 <= y1 && {1'b0, x1} < (COL_W+1)'(COLS) && {1'b0, y1} < (ROW_W+1)'(ROWS);
`ifdef VIDEO_FILL_VBLANK_GATE_EN
  assign adv = !cpu_req && vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign adv = !cpu_req;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cx            <= '0;
      cy            <= '0;
      lx0           <= '0;
      lx1           <= '0;
      ly1           <= '0;
      color         <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      data_in       <= '0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      fill_err      <= 1'b0;
    end else begin
      write_enable  <= cpu_req || (state == FILL && adv);
      write_address <= cpu_req ? {cpu_col, cpu_row} : {cx, cy};
      data_in       <= cpu_req ? cpu_color : color;
      fill_done     <= state == DONE;
      fill_err      <= state == IDLE && fill_start && !valid;
      case (state)
        IDLE: if (fill_start && valid) begin
          lx0       <= x0;
          lx1       <= x1;
          ly1       <= y1;
          color     <= fill_color;
          cx        <= x0;
          cy        <= y0;
          state     <= FILL;
          fill_busy <= 1'b1;
        end
        FILL: if (adv) begin
          if (cx < lx1) cx <= cx + 1'b1;
          else if (cy < ly1) begin
            cx <= lx0;
            cy <= cy + 1'b1;
          end else begin
            state     <= DONE;
            fill_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_fill_arbiter.sv
// tb_video_fill_arbiter: randomized self-checking bench for video_fill_arbiter against a pixel-list reference model.
module tb_video_fill_arbiter;
`ifdef VIDEO_FILL_VBLANK_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 0, fill_start = 0, vblank = 1;
  logic [5:0] cpu_col = 0, x0 = 0, x1 = 0;
  logic [5:0] cpu_row = 0, y0 = 0, y1 = 0;
  logic [2:0] cpu_color = 0, fill_color = 0;
  logic write_enable, fill_busy, fill_done, fill_err;
  logic [11:0] write_address;
  logic [2:0] data_in;
  always #5 clk = ~clk;
  video_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_col(cpu_col), .cpu_row(cpu_row),
    .cpu_color(cpu_color), .fill_start(fill_start), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .fill_color(fill_color), .vblank(vblank), .write_enable(write_enable),
    .write_address(write_address), .data_in(data_in), .fill_busy(fill_busy),
    .fill_done(fill_done), .fill_err(fill_err)
  );
  typedef struct packed {logic [11:0] a; logic [2:0] d; logic [31:0] c;} wr_t;
  wr_t obs[$];
  int checks = 0, errors = 0;
  logic [31:0] cyc = 0, done_c = 0, err_c = 0;
  int busy_n = 0, done_n = 0, err_n = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (write_enable) obs.push_back({write_address, data_in, cyc});
    if (fill_busy) busy_n++;
    if (fill_done) begin done_n++; done_c = cyc; end
    if (fill_err) begin err_n++; err_c = cyc; end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    obs.delete();
    busy_n = 0;
    done_n = 0;
    err_n = 0;
  endtask
  task automatic run_fill(input int ax0, ax1, ay0, ay1, input logic [2:0] col, input int cpu_pct,
                          input logic [15:0] cpu_at, input bit vb_toggle, input bit poke, input string name);
    logic [11:0] px[$];
    logic [11:0] p;
    wr_t e[$];
    int k, exp_busy;
    bit c_req, vb;
    logic [31:0] last_c;
    for (int y = ay0; y <= ay1; y++)
      for (int x = ax0; x <= ax1; x++) px.push_back({6'(x), 6'(y)});
    clear_mon();
    k = 0;
    exp_busy = 0;
    last_c = 0;
    while (px.size() > 0 && k < 8000) begin
      c_req = (k < 16 && cpu_at[k]) || ($urandom_range(99) < cpu_pct);
      vb = vb_toggle ? ((k / 8) % 2 == 1) : 1'b1;
      cpu_req = c_req;
      cpu_col = 6'($urandom);
      cpu_row = 6'($urandom);
      cpu_color = 3'($urandom);
      vblank = vb;
      if (k == 0) begin
        fill_start = 1;
        x0 = 6'(ax0); x1 = 6'(ax1); y0 = 6'(ay0); y1 = 6'(ay1);
        fill_color = col;
      end else begin
        fill_start = poke && (k == 2 || k == 3);
        x0 = (k == 3) ? 6'd9 : 6'($urandom_range(59));
        x1 = (k == 3) ? 6'd8 : 6'd59;
        y0 = 6'd0;
        y1 = 6'd39;
        fill_color = 3'($urandom);
      end
      if (c_req) e.push_back({cpu_col, cpu_row, cpu_color, cyc + 32'd1});
      else if (k > 0 && (!GATE || vb)) begin
        p = px.pop_front();
        e.push_back({p, col, cyc + 32'd1});
        last_c = cyc + 32'd1;
      end
      if (k > 0) exp_busy++;
      step();
      k++;
    end
    cpu_req = 0;
    vblank = 1;
    fill_start = poke;
    x0 = 0; x1 = 0; y0 = 0; y1 = 0;
    step();
    fill_start = 0;
    repeat (4) step();
    checks++;
    if (px.size() != 0) begin errors++; $display("FAIL %s model_budget left=%0d required=0", name, px.size()); end
    checks++;
    if (obs.size() != e.size()) begin errors++; $display("FAIL %s write_count got=%0d exp=%0d", name, obs.size(), e.size()); end
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== e[i]) begin
        errors++;
        $display("FAIL %s write[%0d] got addr=%h data=%0d cyc=%0d exp addr=%h data=%0d cyc=%0d",
                 name, i, obs[i].a, obs[i].d, obs[i].c, e[i].a, e[i].d, e[i].c);
      end
    end
    checks++;
    if (busy_n != exp_busy) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n, exp_busy); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", name, done_n); end
    checks++;
    if (done_c !== last_c + 32'd1) begin errors++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_c, last_c + 1); end
    checks++;
    if (err_n != 0) begin errors++; $display("FAIL %s err_count got=%0d exp=0", name, err_n); end
  endtask
  task automatic test_reset();
    rst_n = 0;
    cpu_req = 1;
    fill_start = 1;
    x0 = 0; x1 = 3; y0 = 0; y1 = 3;
    repeat (3) step();
    checks++;
    if ({write_enable, write_address, data_in, fill_busy, fill_done, fill_err} !== 18'd0) begin
      errors++;
      $display("FAIL reset_hold outputs got=%h exp=0", {write_enable, write_address, data_in, fill_busy, fill_done, fill_err});
    end
    cpu_req = 0;
    fill_start = 0;
    rst_n = 1;
    repeat (3) step();
    checks++;
    if ({write_enable, write_address, data_in, fill_busy, fill_done, fill_err} !== 18'd0) begin
      errors++;
      $display("FAIL reset_idle outputs got=%h exp=0", {write_enable, write_address, data_in, fill_busy, fill_done, fill_err});
    end
  endtask
  task automatic test_cpu_write();
    logic [31:0] r;
    logic exp_we;
    cpu_req = 1; cpu_col = 6'd10; cpu_row = 6'd5; cpu_color = 3'b101;
    step();
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({write_enable, write_address, data_in} !== {1'b1, 6'd10, 6'd5, 3'd5}) begin
      errors++;
      $display("FAIL cpu_write got we=%b addr=%h data=%0d exp we=1 addr=%h data=5", write_enable, write_address, data_in, {6'd10, 6'd5});
    end
    step();
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b0) begin errors++; $display("FAIL cpu_write_pulse got we=%b exp=0", write_enable); end
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      exp_we = r[0] | r[1];
      cpu_req = exp_we;
      cpu_col = r[7:2]; cpu_row = r[13:8]; cpu_color = r[16:14];
      step();
      @(negedge clk);
      checks++;
      if (write_enable !== exp_we) begin errors++; $display("FAIL cpu_rand_we[%0d] got=%b exp=%b", i, write_enable, exp_we); end
      if (exp_we) begin
        checks++;
        if ({write_address, data_in} !== {r[7:2], r[13:8], r[16:14]}) begin
          errors++;
          $display("FAIL cpu_rand_data[%0d] got=%h exp=%h", i, {write_address, data_in}, {r[7:2], r[13:8], r[16:14]});
        end
      end
    end
    cpu_req = 0;
    step();
  endtask
  task automatic test_fill_basic();
    run_fill(3, 4, 4, 5, 3'd2, 0, 16'h0, 1'b0, 1'b0, "fill_basic");
  endtask
  task automatic test_fill_cpu();
    run_fill(3, 4, 4, 5, 3'd2, 0, 16'b100, 1'b0, 1'b0, "fill_cpu_stall");
  endtask
  task automatic test_back_to_back();
    run_fill(5, 7, 1, 1, 3'd6, 0, 16'b0110_0011, 1'b0, 1'b1, "fill_b2b_poke");
  endtask
  task automatic test_errors();
    int bx0[4] = '{9, 0, 5, 10};
    int bx1[4] = '{8, 3, 60, 12};
    int by0[4] = '{0, 2, 0, 7};
    int by1[4] = '{3, 40, 1, 6};
    logic [31:0] c;
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      c = cyc;
      fill_start = 1;
      x0 = 6'(bx0[i]); x1 = 6'(bx1[i]); y0 = 6'(by0[i]); y1 = 6'(by1[i]);
      step();
      fill_start = 0;
      repeat (4) step();
      checks++;
      if (err_n != 1 || err_c !== c + 32'd1) begin errors++; $display("FAIL bad_bounds[%0d] err got=%0d@%0d exp=1@%0d", i, err_n, err_c, c + 1); end
      checks++;
      if (obs.size() != 0 || busy_n != 0) begin errors++; $display("FAIL bad_bounds_quiet[%0d] writes=%0d busy=%0d exp 0 0", i, obs.size(), busy_n); end
    end
  endtask
  task automatic test_random();
    int ax0, ax1, ay0, ay1;
    for (int i = 0; i < 6; i++) begin
      ax0 = $urandom_range(59);
      ax1 = $urandom_range(ax0 + 7 > 59 ? 59 : ax0 + 7, ax0);
      ay0 = $urandom_range(39);
      ay1 = $urandom_range(ay0 + 5 > 39 ? 39 : ay0 + 5, ay0);
      run_fill(ax0, ax1, ay0, ay1, 3'($urandom), 30, 16'($urandom),
               1'($urandom), (ax1 - ax0 + 1) * (ay1 - ay0 + 1) >= 4, "fill_random");
    end
  endtask
  task automatic test_full_screen();
    run_fill(0, 59, 0, 39, 3'd0, 0, 16'h0, 1'b0, 1'b0, "fill_full");
    checks++;
    if (obs.size() != 2400) begin errors++; $display("FAIL full_count got=%0d exp=2400", obs.size()); end
    checks++;
    if (obs.size() == 0 || obs[obs.size()-1].a !== {6'd59, 6'd39}) begin
      errors++;
      $display("FAIL full_last_addr got=%h exp=%h", obs.size() ? obs[obs.size()-1].a : 12'h0, {6'd59, 6'd39});
    end
  endtask
  task automatic test_reset_mid();
    int n, n0;
    clear_mon();
    fill_start = 1;
    x0 = 0; x1 = 59; y0 = 0; y1 = 39; fill_color = 3'd4;
    step();
    fill_start = 0;
    n = 0;
    while (obs.size() < 100 && n < 1000) begin step(); n++; end
    checks++;
    if (obs.size() < 100) begin errors++; $display("FAIL midreset_wait writes=%0d exp>=100", obs.size()); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({write_enable, fill_busy, write_address, data_in} !== 17'd0) begin
      errors++;
      $display("FAIL midreset_async got we=%b busy=%b addr=%h data=%0d exp all 0", write_enable, fill_busy, write_address, data_in);
    end
    n0 = obs.size();
    repeat (3) step();
    rst_n = 1;
    repeat (4) step();
    checks++;
    if (done_n != 0 || obs.size() != n0 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort done=%0d writes=%0d busy=%b exp done=0 writes=%0d busy=0", done_n, obs.size(), fill_busy, n0);
    end
  endtask
  task automatic test_vblank();
    run_fill(2, 3, 7, 8, 3'd6, 0, 16'h0, 1'b1, 1'b0, "fill_vblank");
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL vblank_count got=%0d exp=4", obs.size()); end
    run_fill(10, 13, 20, 22, 3'd3, 25, 16'h0, 1'b1, 1'b1, "fill_vblank_cpu");
  endtask
  initial begin
    test_reset();
    test_cpu_write();
    test_fill_basic();
    test_fill_cpu();
    test_back_to_back();
    test_errors();
    test_random();
    test_vblank();
    test_full_screen();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
